// File: rtl/nrisc_pkg.sv
// nrisc shared package: PC control encodings and default widths.
// Imported by the PC unit, its bus interface and the return stack.
package nrisc_pkg;

  localparam int DEF_TAM = 16;

  localparam logic [1:0] PC_INC  = 2'b00;
  localparam logic [1:0] PC_HOLD = 2'b01;
  localparam logic [1:0] PC_ABS  = 2'b10;
  localparam logic [1:0] PC_REL  = 2'b11;

endpackage

// File: rtl/nrisc_pc_unit_if.sv
// Core <-> PC unit bus: control from the core,
// fetch address and stack status back to it.
interface nrisc_pc_unit_if
  import nrisc_pkg::*;
#(
  parameter int TAM = DEF_TAM
);

  logic [1:0]     CORE_PC_ctrl;
  logic [TAM-1:0] CORE_PC_target;
  logic           CORE_PC_call;
  logic           CORE_PC_ret;
  logic [TAM-1:0] IDATA_ADDR;
  logic           IDATA_rd;
  logic           STACK_ovf;
  logic           STACK_unf;

  modport master (
    output CORE_PC_ctrl,
    output CORE_PC_target,
    output CORE_PC_call,
    output CORE_PC_ret,
    input  IDATA_ADDR,
    input  IDATA_rd,
    input  STACK_ovf,
    input  STACK_unf
  );

  modport slave (
    input  CORE_PC_ctrl,
    input  CORE_PC_target,
    input  CORE_PC_call,
    input  CORE_PC_ret,
    output IDATA_ADDR,
    output IDATA_rd,
    output STACK_ovf,
    output STACK_unf
  );

endinterface

// File: rtl/nrisc_ret_stack.sv
// Return-address stack with occupancy pointer 0..DEPTH.
// Entries are unreset; only the pointer is cleared.
module nrisc_ret_stack
  import nrisc_pkg::*;
#(
  parameter int W     = DEF_TAM,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] push_data,
  output logic [W-1:0] top,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW:0]   ptr;
  logic [AW-1:0] wr_idx;
  logic [AW-1:0] top_idx;
  logic          do_push;
  logic          do_pop;

  assign full    = (ptr == (AW+1)'(DEPTH));
  assign empty   = (ptr == '0);
  assign wr_idx  = ptr[AW-1:0];
  assign top_idx = wr_idx - AW'(1);
  assign top     = mem[top_idx];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr <= '0;
    end else if (do_push && !do_pop) begin
      ptr <= ptr + (AW+1)'(1);
    end else if (do_pop && !do_push) begin
      ptr <= ptr - (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_idx] <= push_data;
    end
  end

endmodule

// File: rtl/nrisc_pc_unit.sv
// nrisc program counter: inc/hold/abs/rel with call/ret stack.
// Priority is ret > call > ctrl; all outputs are registered.
module nrisc_pc_unit
  import nrisc_pkg::*;
#(
  parameter int             TAM          = DEF_TAM,
  parameter int             STACK_DEPTH  = 4,
  parameter logic [TAM-1:0] RESET_VECTOR = '0
) (
  input  logic             clk,
  input  logic             rst,
  nrisc_pc_unit_if.slave   bus
);

  logic [TAM-1:0] pc_q;
  logic [TAM-1:0] pc_n;
  logic [TAM-1:0] pc_inc;
  logic [TAM-1:0] top;
  logic [1:0]     ctrl;
  logic           rd_q;
  logic           rd_n;
  logic           ovf_q;
  logic           ovf_n;
  logic           unf_q;
  logic           unf_n;
  logic           push;
  logic           pop;
  logic           full;
  logic           empty;

  assign ctrl   = bus.CORE_PC_ctrl;
  assign pc_inc = pc_q + TAM'(1);
  assign rd_n   = !((ctrl == PC_HOLD) && !bus.CORE_PC_ret);

  always_comb begin
    pc_n  = pc_q;
    push  = 1'b0;
    pop   = 1'b0;
    ovf_n = ovf_q;
    unf_n = unf_q;
    if (bus.CORE_PC_ret) begin
      if (!empty) begin
        pc_n = top;
        pop  = 1'b1;
      end else begin
        pc_n  = RESET_VECTOR;
        unf_n = 1'b1;
      end
    end else begin
      unique case (1'b1)
        (ctrl == PC_INC):  pc_n = pc_inc;
        (ctrl == PC_HOLD): pc_n = pc_q;
        (ctrl == PC_ABS): begin
          pc_n = bus.CORE_PC_target;
          // overflowing call still jumps, only the push is dropped
          if (bus.CORE_PC_call) begin
            if (full) ovf_n = 1'b1;
            else      push  = 1'b1;
          end
        end
        (ctrl == PC_REL):  pc_n = pc_q + bus.CORE_PC_target;
        default:           pc_n = pc_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q  <= RESET_VECTOR;
      rd_q  <= 1'b0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      pc_q  <= pc_n;
      rd_q  <= rd_n;
      ovf_q <= ovf_n;
      unf_q <= unf_n;
    end
  end

  nrisc_ret_stack #(
    .W     (TAM),
    .DEPTH (STACK_DEPTH)
  ) u_stack (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .pop       (pop),
    .push_data (pc_inc),
    .top       (top),
    .full      (full),
    .empty     (empty)
  );

  assign bus.IDATA_ADDR = pc_q;
  assign bus.IDATA_rd   = rd_q;
  assign bus.STACK_ovf  = ovf_q;
  assign bus.STACK_unf  = unf_q;

endmodule

// File: tb/tb_nrisc_pc_unit.sv
// Scoreboard bench for nrisc_pc_unit: directed vectors queue
// expected outputs, a monitor checks them after each edge.
module tb_nrisc_pc_unit;
  import nrisc_pkg::*;

  typedef struct {
    string       name;
    logic [15:0] addr;
    logic        rd;
    logic        ovf;
    logic        unf;
  } exp_t;

  logic clk;
  logic rst;
  int   checks;
  int   passed;
  exp_t q[$];

  nrisc_pc_unit_if #(.TAM(16)) bus ();

  nrisc_pc_unit #(
    .TAM          (16),
    .STACK_DEPTH  (4),
    .RESET_VECTOR (16'h0000)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(string n, logic [31:0] got, logic [31:0] want);
    checks++;
    if (got === want) passed++;
    else $display("FAIL %s: got %0h want %0h", n, got, want);
  endtask

  task automatic chk_all(exp_t e);
    chk({e.name, ".addr"}, 32'(bus.IDATA_ADDR), 32'(e.addr));
    chk({e.name, ".rd"},   32'(bus.IDATA_rd),   32'(e.rd));
    chk({e.name, ".ovf"},  32'(bus.STACK_ovf),  32'(e.ovf));
    chk({e.name, ".unf"},  32'(bus.STACK_unf),  32'(e.unf));
  endtask

  task automatic drive(logic [1:0] c, logic [15:0] t, logic cl,
                       logic r, logic [15:0] ea, logic erd,
                       logic eovf, logic eunf, string n);
    exp_t e;
    bus.CORE_PC_ctrl   = c;
    bus.CORE_PC_target = t;
    bus.CORE_PC_call   = cl;
    bus.CORE_PC_ret    = r;
    e.name = n;
    e.addr = ea;
    e.rd   = erd;
    e.ovf  = eovf;
    e.unf  = eunf;
    q.push_back(e);
  endtask

  task automatic step(logic [1:0] c, logic [15:0] t, logic cl,
                      logic r, logic [15:0] ea, logic erd,
                      logic eovf, logic eunf, string n);
    @(negedge clk);
    drive(c, t, cl, r, ea, erd, eovf, eunf, n);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk_all(e);
      end
    end
  end

  initial begin : stim
    exp_t r0;
    checks = 0;
    passed = 0;
    rst = 1'b0;
    bus.CORE_PC_ctrl   = PC_HOLD;
    bus.CORE_PC_target = '0;
    bus.CORE_PC_call   = 1'b0;
    bus.CORE_PC_ret    = 1'b0;
    #3;
    r0.name = "reset";
    r0.addr = 16'h0000;
    r0.rd   = 1'b0;
    r0.ovf  = 1'b0;
    r0.unf  = 1'b0;
    chk_all(r0);
    repeat (2) @(posedge clk);
    #1 chk_all(r0);

    @(negedge clk);
    rst = 1'b1;
    drive(PC_INC, 16'h0, 0, 0, 16'h0001, 1, 0, 0, "inc1");
    step(PC_INC,  16'h0,    0, 0, 16'h0002, 1, 0, 0, "inc2");
    step(PC_INC,  16'h0,    0, 0, 16'h0003, 1, 0, 0, "inc3");
    step(PC_ABS,  16'h0010, 0, 0, 16'h0010, 1, 0, 0, "abs10");
    step(PC_REL,  16'hFFFE, 0, 0, 16'h000E, 1, 0, 0, "rel_neg");
    step(PC_ABS,  16'hFFFF, 0, 0, 16'hFFFF, 1, 0, 0, "abs_max");
    step(PC_INC,  16'h0,    0, 0, 16'h0000, 1, 0, 0, "wrap");
    step(PC_HOLD, 16'h1234, 1, 0, 16'h0000, 0, 0, 0, "hold");

    step(PC_ABS,  16'h0020, 0, 0, 16'h0020, 1, 0, 0, "to20");
    step(PC_ABS,  16'h0100, 1, 0, 16'h0100, 1, 0, 0, "call100");
    step(PC_INC,  16'h0,    0, 1, 16'h0021, 1, 0, 0, "ret21");

    step(PC_ABS,  16'h0200, 1, 0, 16'h0200, 1, 0, 0, "call1");
    step(PC_ABS,  16'h0300, 1, 0, 16'h0300, 1, 0, 0, "call2");
    step(PC_ABS,  16'h0400, 1, 0, 16'h0400, 1, 0, 0, "call3");
    step(PC_ABS,  16'h0500, 1, 0, 16'h0500, 1, 0, 0, "call4");
    step(PC_ABS,  16'h0600, 1, 0, 16'h0600, 1, 1, 0, "call5_ovf");
    step(PC_HOLD, 16'h0,    0, 1, 16'h0401, 1, 1, 0, "ret4");
    step(PC_REL,  16'h0040, 0, 1, 16'h0301, 1, 1, 0, "ret3");
    step(PC_HOLD, 16'h0,    1, 1, 16'h0201, 1, 1, 0, "ret2");
    step(PC_INC,  16'h0,    0, 1, 16'h0022, 1, 1, 0, "ret1");
    step(PC_HOLD, 16'h0,    0, 1, 16'h0000, 1, 1, 1, "ret_unf");

    step(PC_INC,  16'h0,    1, 0, 16'h0001, 1, 1, 1, "call_inc");
    step(PC_INC,  16'h0,    0, 1, 16'h0000, 1, 1, 1, "no_push");
    step(PC_ABS,  16'h0040, 1, 0, 16'h0040, 1, 1, 1, "call40");
    step(PC_ABS,  16'h0080, 1, 1, 16'h0001, 1, 1, 1, "ret_wins");
    step(PC_INC,  16'h0,    0, 1, 16'h0000, 1, 1, 1, "no_push2");
    step(PC_INC,  16'h0,    0, 0, 16'h0001, 1, 1, 1, "pre_rst");

    @(negedge clk);
    bus.CORE_PC_ctrl   = PC_ABS;
    bus.CORE_PC_target = 16'h0700;
    bus.CORE_PC_call   = 1'b1;
    bus.CORE_PC_ret    = 1'b0;
    #2 rst = 1'b0;
    #1 chk_all(r0);
    @(negedge clk);
    rst = 1'b1;
    drive(PC_INC, 16'h0, 0, 1, 16'h0000, 1, 0, 1, "post_rst_ret");
    step(PC_INC,  16'h0,    0, 0, 16'h0001, 1, 0, 1, "post_inc");

    repeat (3) @(negedge clk);
    chk("queue_drained", 32'(q.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/nrisc_pc_unit.md
NRISC_PC_UNIT -- requirements
Module: nrisc_pc_unit

Interface
REQ-001 Parameter TAM, default 16: instruction address width in bits.
REQ-002 Parameter STACK_DEPTH, default 4: return-address stack entries (power of two, at least 2).
REQ-003 Parameter RESET_VECTOR, default 0: PC value loaded on reset and on return-stack underflow.
REQ-004 clk  in  1: single clock; all state updates on its rising edge.
REQ-005 rst  in  1: reset, asynchronous, active-low.
REQ-006 CORE_PC_ctrl  in  2: PC operation select, driven by the core.
REQ-007 CORE_PC_target  in  TAM: absolute target (ctrl=10) or two's-complement offset (ctrl=11).
REQ-008 CORE_PC_call  in  1: push return address, qualified only when ctrl=10.
REQ-009 CORE_PC_ret  in  1: pop return address into PC.
REQ-010 IDATA_ADDR  out  TAM: registered instruction address presented to instruction memory.
REQ-011 IDATA_rd  out  1: instruction-fetch request, registered.
REQ-012 STACK_ovf  out  1: sticky flag, a push occurred while the stack was full.
REQ-013 STACK_unf  out  1: sticky flag, a pop occurred while the stack was empty.

Function
REQ-014 Encoding SHALL be: 00 = PC+1, 01 = hold, 10 = PC <= target, 11 = PC <= PC + target.
REQ-015 All arithmetic SHALL be modulo 2^TAM: PC = all-ones with ctrl=00 wraps to 0, and negative offsets wrap.
REQ-016 IDATA_ADDR SHALL reflect the new PC exactly one clock after the controls are sampled, with no combinational path from inputs to outputs.
REQ-017 Priority SHALL be ret > call > ctrl; when ret and call are both high, call is ignored.
REQ-018 ret on a non-empty stack SHALL load the PC from the top entry and decrement the stack pointer, regardless of ctrl.
REQ-019 ret on an empty stack SHALL load RESET_VECTOR, set STACK_unf, and leave the pointer unchanged.
REQ-020 call with ctrl=10 on a non-full stack SHALL push PC+1 (modulo 2^TAM) and load the target, both on the same edge.
REQ-021 call with ctrl=10 on a full stack SHALL set STACK_ovf, drop the push, leave contents unchanged, and still load the target.
REQ-022 call with ctrl other than 10 SHALL be ignored; ctrl then executes normally.
REQ-023 Hold (01) with no ret SHALL keep the PC and the stack unchanged.
REQ-024 STACK_ovf and STACK_unf SHALL stay set once set, and only reset clears them.
REQ-025 IDATA_rd SHALL be 0 during reset and 1 from the first rising clk edge after rst deasserts.
REQ-026 IDATA_rd SHALL be 0 during any cycle whose sampled ctrl was 01 with no ret, and 1 otherwise.
REQ-027 Stack occupancy SHALL range 0..STACK_DEPTH; full means occupancy = STACK_DEPTH, empty means occupancy = 0.

Reset
REQ-028 rst low SHALL immediately set: IDATA_ADDR = RESET_VECTOR, IDATA_rd = 0, stack pointer = 0 (empty), STACK_ovf = 0, STACK_unf = 0.
REQ-029 Stack entry contents SHALL need no reset; they are never read while empty.
REQ-030 Reset asserted mid-operation SHALL discard any pending push or pop; the first post-reset edge SHALL act on the controls sampled at that edge.

Structure
REQ-031 Shared package nrisc_pkg SHALL hold the PC_ctrl encoding constants (PC_INC, PC_HOLD, PC_ABS, PC_REL) and the default TAM.
REQ-032 The return stack SHALL be a separate sub-module, nrisc_ret_stack, providing push, pop, top, full and empty; the PC register and priority logic SHALL stay in nrisc_pc_unit.

Verification
REQ-033 Release reset, ctrl=00 for 3 cycles -> IDATA_ADDR 0,1,2,3; IDATA_rd 0 during reset, then 1.
REQ-034 PC=0x0010, ctrl=11, target=0xFFFE -> next IDATA_ADDR 0x000E; PC=0xFFFF, ctrl=00 -> 0x0000.
REQ-035 PC=0x0020, call, ctrl=10, target=0x0100; then ret -> addresses 0x0100, then 0x0021; STACK_ovf = STACK_unf = 0.
REQ-036 Five nested calls (depth 4) -> fifth sets STACK_ovf and still jumps; four rets return correctly; fifth ret -> RESET_VECTOR and STACK_unf = 1.
REQ-037 call and ret high with ctrl=10 after one call -> pop wins, PC = pushed address, no push occurs.
REQ-038 Assert rst mid-call cycle, then release -> IDATA_ADDR = RESET_VECTOR, stack empty, flags 0, next ret sets STACK_unf.
